// File: rtl/reg_bank_pkg.sv
// Shared types and helpers for the reg_bank register file.
// Holds the default data width, byte-lane count and byte-merge helper.
package reg_bank_pkg;

    localparam int DATA_W_DEF = 32;

    // Widest word the merge helper handles; callers zero-extend into it.
    localparam int MAX_W  = 256;
    localparam int MAX_BE = MAX_W / 8;

    function automatic int lanes(input int w);
        return w / 8;
    endfunction

    // Replace each byte of old_w whose enable is set with the byte of new_w.
    function automatic logic [MAX_W-1:0] merge_bytes(
        input logic [MAX_W-1:0]  old_w,
        input logic [MAX_W-1:0]  new_w,
        input logic [MAX_BE-1:0] be
    );
        logic [MAX_W-1:0] m;
        m = old_w;
        for (int i = 0; i < MAX_BE; i++) begin
            if (be[i]) begin
                m[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/reg_bank_rdport.sv
// One registered read port of reg_bank with write-first bypass.
// Ports: clk/reset, rd_en/rd_addr request, regs (storage view),
// wr_ok/wr_addr/wr_data/wr_be (accepted write this edge),
// rd_data (tri-state, driven while rd_valid), rd_valid.
module reg_bank_rdport
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [DATA_W-1:0]    regs [NUM_REGS],
    input  logic                 wr_ok,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [DATA_W/8-1:0]  wr_be,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 rd_valid
);

    logic [DATA_W-1:0] q;
    logic [DATA_W-1:0] nxt;
    logic [MAX_W-1:0]  merged;

    // Unmatched (out-of-range) addresses fall through to zero.
    always_comb begin
        nxt    = '0;
        merged = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                nxt = regs[i];
            end
        end
        // wr_ok implies wr_addr is in range, so a match implies rd_addr is too.
        if (wr_ok && (wr_addr == rd_addr)) begin
            merged = merge_bytes(MAX_W'(nxt), MAX_W'(wr_data), MAX_BE'(wr_be));
            nxt    = merged[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q        <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                q <= nxt;
            end
        end
    end

    // Both terms come straight from flops, so the bus never sees X.
    assign rd_data = rd_valid ? q : 'z;

endmodule

// File: rtl/reg_bank.sv
// Parametrised flop-based register bank with sticky per-entry write locks.
// Ports: clk, reset (sync, active-high); write port wr_en/wr_addr/wr_data/
// wr_be with wr_err pulse; lock_en/lock_addr with locked bits; read ports
// A and B (rd_x_en/rd_x_addr in, rd_x_data tri-state + rd_x_valid out).
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic [DATA_W/8-1:0]  wr_be,
    output logic                 wr_err,
    input  logic                 lock_en,
    input  logic [ADDR_W-1:0]    lock_addr,
    output logic [NUM_REGS-1:0]  locked,
    input  logic                 rd_a_en,
    input  logic [ADDR_W-1:0]    rd_a_addr,
    output logic [DATA_W-1:0]    rd_a_data,
    output logic                 rd_a_valid,
    input  logic                 rd_b_en,
    input  logic [ADDR_W-1:0]    rd_b_addr,
    output logic [DATA_W-1:0]    rd_b_data,
    output logic                 rd_b_valid
);

    localparam int BE_W = lanes(DATA_W);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] lock_hit;
    logic                wr_ok;

    function automatic logic [DATA_W-1:0] merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [MAX_W-1:0] m;
        m = merge_bytes(MAX_W'(old_w), MAX_W'(new_w), MAX_BE'(be));
        return m[DATA_W-1:0];
    endfunction

    // Out-of-range addresses match no entry, so they never hit.
    always_comb begin
        wr_hit   = '0;
        lock_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wr_hit[i]   = wr_en && (wr_addr == ADDR_W'(i));
            lock_hit[i] = lock_en && (lock_addr == ADDR_W'(i));
        end
        // Judged against pre-edge locks: a same-edge lock still lets the write in.
        wr_ok = |(wr_hit & ~locked);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            locked <= '0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            locked <= locked | lock_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i] && !locked[i]) begin
                    regs[i] <= merge(regs[i], wr_data, wr_be);
                end
            end
        end
    end

    reg_bank_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd_a (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_a_en),
        .rd_addr  (rd_a_addr),
        .regs     (regs),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_data  (rd_a_data),
        .rd_valid (rd_a_valid)
    );

    reg_bank_rdport #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd_b (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_b_en),
        .rd_addr  (rd_b_addr),
        .regs     (regs),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_be    (wr_be),
        .rd_data  (rd_b_data),
        .rd_valid (rd_b_valid)
    );

endmodule
